// File: rtl/popcount_ternary_sched_pkg.sv
// Shared definitions for the ternary popcount sequencer and related neuron blocks.
// Holds FSM state codes, ternary activation encoding and accumulator sizing.
package popcount_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] ACT_POS  = 2'b01;
    localparam logic [1:0] ACT_ZERO = 2'b00;
    localparam logic [1:0] ACT_NEG  = 2'b11;

    // Signed width covering -7*n..+7*n, since an approximate unit may return 7 per chunk.
    function automatic int unsigned acc_width(input int unsigned n);
        return $clog2(7 * n + 1) + 1;
    endfunction

endpackage

// File: rtl/popcount_ternary_sched_if.sv
// Request/result handshake plus the link to the external shared popcount unit.
// master = environment (source, consumer, popcount unit); slave = the sequencer.
interface popcount_ternary_sched_if #(
    parameter int unsigned N_CHUNKS = 8,
    parameter int unsigned THR_W    = 6
);
    import popcount_pkg::*;

    localparam int unsigned ACC_W = acc_width(N_CHUNKS);

    logic                  in_valid;
    logic                  in_ready;
    logic [4*N_CHUNKS-1:0] in_pos;
    logic [4*N_CHUNKS-1:0] in_neg;
    logic [THR_W-1:0]      in_thr;
    logic [3:0]            pc_a;
    logic [2:0]            pc_sum;
    logic                  out_valid;
    logic                  out_ready;
    logic [1:0]            out_act;
    logic [ACC_W-1:0]      out_sum;

    modport master (
        output in_valid, in_pos, in_neg, in_thr, pc_sum, out_ready,
        input  in_ready, pc_a, out_valid, out_act, out_sum
    );

    modport slave (
        input  in_valid, in_pos, in_neg, in_thr, pc_sum, out_ready,
        output in_ready, pc_a, out_valid, out_act, out_sum
    );

endinterface

// File: rtl/popcount_ternary_sched_cmp.sv
// Symmetric-threshold ternary activation: +1 if sum > T, -1 if sum < -T, else 0.
// Purely combinational; T is unsigned and zero-extended before the signed compare.
module ternary_act_cmp
    import popcount_pkg::*;
#(
    parameter int unsigned ACC_W = 7,
    parameter int unsigned THR_W = 6
) (
    input  logic signed [ACC_W-1:0] sum,
    input  logic        [THR_W-1:0] thr,
    output logic        [1:0]       act
);

    localparam int unsigned CMP_W = ((ACC_W > THR_W + 1) ? ACC_W : THR_W + 1) + 1;

    logic signed [CMP_W-1:0] sum_x;
    logic signed [CMP_W-1:0] thr_x;
    logic signed [CMP_W-1:0] thr_neg;

    assign sum_x   = CMP_W'(sum);
    assign thr_x   = CMP_W'(thr);
    assign thr_neg = -thr_x;

    always_comb begin
        act = ACT_ZERO;
        if (sum_x > thr_x) begin
            act = ACT_POS;
        end else if (sum_x < thr_neg) begin
            act = ACT_NEG;
        end
    end

endmodule

// File: rtl/popcount_ternary_sched.sv
// Time-multiplexes one external 4-bit popcount unit over a wide ternary input vector,
// accumulating (+pos hits) - (neg hits) chunk by chunk, then thresholds the result.
module popcount_ternary_sched
    import popcount_pkg::*;
#(
    parameter int unsigned N_CHUNKS = 8,
    parameter int unsigned THR_W    = 6
) (
    input logic                     clk,
    input logic                     rst,
    popcount_ternary_sched_if.slave bus
);

    localparam int unsigned ACC_W = acc_width(N_CHUNKS);
    localparam int unsigned VEC_W = 4 * N_CHUNKS;
    localparam int unsigned IDX_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

    logic [1:0]              state_q;
    logic                    phase_neg_q;
    logic [IDX_W-1:0]        idx_q;
    logic [VEC_W-1:0]        pos_q;
    logic [VEC_W-1:0]        neg_q;
    logic [THR_W-1:0]        thr_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] pc_ext;
    logic [1:0]              act;

    // pc_sum is trusted as-is (no clamp to popcount(pc_a)); ACC_W absorbs the worst case.
    assign pc_ext = ACC_W'(bus.pc_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_neg_q <= 1'b0;
            idx_q       <= '0;
            pos_q       <= '0;
            neg_q       <= '0;
            thr_q       <= '0;
            acc_q       <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        pos_q       <= bus.in_pos;
                        neg_q       <= bus.in_neg;
                        thr_q       <= bus.in_thr;
                        acc_q       <= '0;
                        idx_q       <= '0;
                        phase_neg_q <= 1'b0;
                        state_q     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (phase_neg_q) begin
                        acc_q <= acc_q - pc_ext;
                    end else begin
                        acc_q <= acc_q + pc_ext;
                    end
                    phase_neg_q <= ~phase_neg_q;
                    if (phase_neg_q) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_DONE;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    ternary_act_cmp #(
        .ACC_W(ACC_W),
        .THR_W(THR_W)
    ) u_cmp (
        .sum(acc_q),
        .thr(thr_q),
        .act(act)
    );

    // Result outputs are gated to DONE so IDLE/RUN never expose a partial sum.
    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE);
        bus.out_valid = (state_q == ST_DONE);
        bus.pc_a      = '0;
        bus.out_sum   = '0;
        bus.out_act   = ACT_ZERO;
        if (state_q == ST_RUN) begin
            bus.pc_a = phase_neg_q ? neg_q[{idx_q, 2'b00} +: 4] : pos_q[{idx_q, 2'b00} +: 4];
        end
        if (state_q == ST_DONE) begin
            bus.out_sum = acc_q;
            bus.out_act = act;
        end
    end

endmodule
